// File: rtl/cordic_sqrt_pkg.sv
// Shared definitions for the hyperbolic-vectoring CORDIC square-root sequencer.
//   - state_t       : controller states
//   - FIRST_REPEAT  : first hyperbolic repeat index
//   - REP_MUL/OFF   : repeat recurrence k' = REP_MUL*k + REP_OFF (4, 13, 40, 121, ...)
//   - DEF_N_ITER / DEF_SHIFT_W : default iteration count and shift width
// Optional feature macro: CORDIC_SQRT_REPEAT_EN (used by cordic_iter_seq).
package cordic_sqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int FIRST_REPEAT = 4;
    localparam int REP_MUL      = 3;
    localparam int REP_OFF      = 1;

    localparam int DEF_N_ITER   = 16;
    localparam int DEF_SHIFT_W  = 5;

endpackage

// File: rtl/cordic_iter_seq.sv
// Iteration index sequencer for the hyperbolic CORDIC loop.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return to the pre-start point (idx = 0, no repeat pending)
//   step       : advance one micro-rotation step (ignored while clear is high)
//   idx        : current iteration index / shift amount
//   last       : current step is the final one (idx == N_ITER, no repeat due)
// idx = 0 is the pre-start value; the first step moves it to 1, so the
// controller steps once during LOAD and enters ITER with idx = 1.
// Macro CORDIC_SQRT_REPEAT_EN: when defined, indices 4, 13, 40, ... are run
// twice (hyperbolic convergence repeats); when undefined, idx runs 1..N_ITER once.
module cordic_iter_seq
    import cordic_sqrt_pkg::*;
#(
    parameter int N_ITER  = DEF_N_ITER,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               step,
    output logic [SHIFT_W-1:0] idx,
    output logic               last
);

`ifdef CORDIC_SQRT_REPEAT_EN
    localparam int REP_W  = SHIFT_W + 2;
    // Two spare bits so 3*k+1 of the widest next_rep cannot overflow before clamping.
    localparam int WIDE_W = REP_W + 2;
    localparam logic [WIDE_W-1:0] REP_MAX = {2'b00, {REP_W{1'b1}}};

    logic              rep_flag;
    logic [REP_W-1:0]  next_rep;
    logic              rep_now;
    logic [WIDE_W-1:0] rep_wide;
    logic [REP_W-1:0]  rep_upd;

    // A repeat is due when the index reaches the threshold and has not been repeated yet.
    assign rep_now = ({2'b00, idx} == next_rep) && !rep_flag;
    assign last    = (idx == SHIFT_W'(N_ITER)) && !rep_now;

    // Saturating recurrence; once saturated the threshold is beyond any idx value.
    always_comb begin
        rep_wide = WIDE_W'(next_rep) * WIDE_W'(REP_MUL) + WIDE_W'(REP_OFF);
        rep_upd  = rep_wide[REP_W-1:0];
        if (rep_wide > REP_MAX) begin
            rep_upd = '1;
        end
    end

    // next_rep idles at its starting threshold rather than 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            rep_flag <= 1'b0;
            next_rep <= REP_W'(FIRST_REPEAT);
        end else if (clear) begin
            idx      <= '0;
            rep_flag <= 1'b0;
            next_rep <= REP_W'(FIRST_REPEAT);
        end else if (step) begin
            if (rep_now) begin
                rep_flag <= 1'b1;
            end else begin
                rep_flag <= 1'b0;
                if (rep_flag) begin
                    next_rep <= rep_upd;
                end
                idx <= idx + 1'b1;
            end
        end
    end
`else
    assign last = (idx == SHIFT_W'(N_ITER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (step) begin
            idx <= idx + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/cordic_sqrt_ctrl.sv
// Sequencer for the hyperbolic-vectoring CORDIC square-root datapath.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand request handshake (accepted in IDLE)
//   abort               : synchronous cancel, highest priority in every state
//   ld_en               : one-cycle datapath load strobe (x = a+0.25, y = a-0.25)
//   it_en               : datapath performs one micro-rotation this cycle
//   shift_amt           : iteration index i during it_en, else 0
//   y_neg               : sign of datapath y register
//   dir                 : rotation direction, y_neg gated by it_en
//   out_valid/out_ready : result handshake, out_valid held until out_ready
//   busy                : high in LOAD, ITER and DONE
// Macro CORDIC_SQRT_REPEAT_EN selects hyperbolic repeat iterations
// (18 steps for N_ITER = 16); undefined gives 16 plain steps.
module cordic_sqrt_ctrl
    import cordic_sqrt_pkg::*;
#(
    parameter int N_ITER  = DEF_N_ITER,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               abort,
    output logic               ld_en,
    output logic               it_en,
    output logic [SHIFT_W-1:0] shift_amt,
    input  logic               y_neg,
    output logic               dir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    state_t             state;
    state_t             state_nxt;
    logic               seq_clear;
    logic               seq_step;
    logic [SHIFT_W-1:0] idx;
    logic               last;

    // Index is held at its pre-start value outside LOAD/ITER and on abort;
    // the LOAD-cycle step brings it to 1 for the first ITER cycle.
    assign seq_clear = abort || (state == ST_IDLE) || (state == ST_DONE);
    assign seq_step  = (state == ST_LOAD) || (state == ST_ITER);

    cordic_iter_seq #(
        .N_ITER  (N_ITER),
        .SHIFT_W (SHIFT_W)
    ) u_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (seq_clear),
        .step  (seq_step),
        .idx   (idx),
        .last  (last)
    );

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (in_valid)  state_nxt = ST_LOAD;
                ST_LOAD:                state_nxt = ST_ITER;
                ST_ITER: if (last)      state_nxt = ST_DONE;
                ST_DONE: if (out_ready) state_nxt = ST_IDLE;
                default:                state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign ld_en     = (state == ST_LOAD);
    assign it_en     = (state == ST_ITER);
    assign shift_amt = it_en ? idx : '0;
    assign dir       = y_neg & it_en;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_cordic_sqrt_ctrl.sv
// Directed bench for cordic_sqrt_ctrl: handshake timing, shift sequence,
// dir gating, DONE hold, abort, asynchronous reset. Expected shift sequences
// are written out by hand for both builds of CORDIC_SQRT_REPEAT_EN.
module tb_cordic_sqrt_ctrl;

    localparam int SHIFT_W = 5;

`ifdef CORDIC_SQRT_REPEAT_EN
    localparam int NSTEPS = 18;
    int exp_seq [NSTEPS] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 16};
`else
    localparam int NSTEPS = 16;
    int exp_seq [NSTEPS] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
`endif

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               abort;
    logic               ld_en;
    logic               it_en;
    logic [SHIFT_W-1:0] shift_amt;
    logic               y_neg;
    logic               dir;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    int checks = 0;
    int errors = 0;

    cordic_sqrt_ctrl #(
        .N_ITER  (16),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .abort     (abort),
        .ld_en     (ld_en),
        .it_en     (it_en),
        .shift_amt (shift_amt),
        .y_neg     (y_neg),
        .dir       (dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Idle-state outputs.
    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready),  1);
        chk({tag, ".ld_en"},     32'(ld_en),     0);
        chk({tag, ".it_en"},     32'(it_en),     0);
        chk({tag, ".shift"},     32'(shift_amt), 0);
        chk({tag, ".dir"},       32'(dir),       0);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".busy"},      32'(busy),      0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the LOAD cycle.
    task automatic accept(input string tag);
        chk({tag, ".in_ready_pre"}, 32'(in_ready), 1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".ld_en"},    32'(ld_en),    1);
        chk({tag, ".in_ready"}, 32'(in_ready), 0);
        chk({tag, ".busy"},     32'(busy),     1);
        chk({tag, ".it_en_ld"}, 32'(it_en),    0);
    endtask

    // Checks the first n ITER cycles with random y_neg.
    task automatic iterate(input string tag, input int n);
        logic yn;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            yn = 1'($urandom_range(0, 1));
            y_neg = yn;
            #1;
            chk({tag, ".it_en"},     32'(it_en),     1);
            chk({tag, ".shift"},     32'(shift_amt), 32'(exp_seq[k]));
            chk({tag, ".dir"},       32'(dir),       32'(yn));
            chk({tag, ".ld_en"},     32'(ld_en),     0);
            chk({tag, ".out_valid"}, 32'(out_valid), 0);
        end
    endtask

    // DONE phase: hold extra cycles with out_ready low, then pulse out_ready.
    task automatic finish(input string tag, input int hold);
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            y_neg    = 1'b1;
            in_valid = (h > 0);
            #1;
            chk({tag, ".out_valid"}, 32'(out_valid), 1);
            chk({tag, ".busy"},      32'(busy),      1);
            chk({tag, ".in_ready"},  32'(in_ready),  0);
            chk({tag, ".it_en"},     32'(it_en),     0);
            chk({tag, ".dir"},       32'(dir),       0);
            chk({tag, ".shift"},     32'(shift_amt), 0);
            chk({tag, ".ld_en"},     32'(ld_en),     0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_idle({tag, ".back"});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        abort     = 1'b0;
        y_neg     = 1'b1;
        out_ready = 1'b0;

        // Reset values, with y_neg and in_valid high to show gating.
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        #1;
        chk_idle("reset");
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (8) @(negedge clk);
        chk_idle("idle");

        // 1/2: full operation with exact latency and dir gating.
        accept("op1");
        iterate("op1", NSTEPS);
        finish("op1", 0);

        // Abort together with in_valid in IDLE: not accepted.
        abort    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk_idle("abort_idle");

        // 3: DONE held 5 extra cycles, in_valid ignored, back-to-back accept.
        accept("op3");
        iterate("op3", NSTEPS);
        finish("op3", 5);
        accept("op3b");
        iterate("op3b", NSTEPS);
        finish("op3b", 0);

        // 4: abort on the 7th ITER cycle, then a clean restart at i = 1.
        accept("op4");
        iterate("op4", 7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort_iter");
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ov", 32'(out_valid), 0);
        end
        accept("op4b");
        iterate("op4b", NSTEPS);
        finish("op4b", 0);

        // 5: asynchronous reset between clock edges mid-ITER.
        accept("op5");
        iterate("op5", 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        @(negedge clk);
        chk_idle("async_rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        accept("op5b");
        iterate("op5b", NSTEPS);
        finish("op5b", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_sqrt_ctrl.md
Name: cordic_sqrt_ctrl

Overview:
Sequencer for the hyperbolic-vectoring CORDIC square-root datapath. It accepts an operand request, pulses the datapath load strobe, and steps the iteration index (shift amount), including the mandatory hyperbolic repeat iterations. It derives each step's rotation direction from the datapath's y sign and signals completion with a valid/ready output handshake. It sits between the operand source and the CORDIC add/sub/shift datapath.

Parameters:
N_ITER, 16, last hyperbolic iteration index; iterations run i = 1..N_ITER.
SHIFT_W, 5, width of shift_amt; must satisfy 2^SHIFT_W > N_ITER.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request
in_ready  output  1  controller idle; request accepted when in_valid & in_ready
abort  input  1  synchronous cancel of the current operation
ld_en  output  1  datapath load strobe: x = a+0.25, y = a-0.25, one cycle
it_en  output  1  datapath performs one micro-rotation this cycle
shift_amt  output  SHIFT_W  current iteration index i; 0 when it_en = 0
y_neg  input  1  sign bit of the datapath y register
dir  output  1  1 = x += y>>i, y += x>>i; 0 = subtract; equals y_neg & it_en
out_valid  output  1  result in datapath is final
out_ready  input  1  consumer takes the result
busy  output  1  high in LOAD, ITER and DONE

Behaviour:
- States: IDLE, LOAD, ITER, DONE. The state register and all counters reset asynchronously to IDLE or 0. All outputs are combinational decodes of the registered state, index and flags.
- Values during reset: in_ready = 1; ld_en, it_en, dir, out_valid and busy = 0; shift_amt = 0.
- IDLE: in_ready = 1. If in_valid and not abort, the next state is LOAD.
- LOAD: ld_en = 1 for exactly one cycle. On entry to ITER: i = 1, rep_flag = 0, next_rep = 4.
- ITER: it_en = 1 and shift_amt = i on every cycle.
  - If i == next_rep and rep_flag == 0, set rep_flag and hold i (repeat step).
  - Otherwise clear rep_flag. If the previous step was a repeat, update next_rep = 3*next_rep + 1. Then increment i.
  - The last step is the cycle with i == N_ITER that is not about to repeat. The next state is DONE.
  - next_rep is SHIFT_W+2 bits wide and saturates, with no wrap-around.
- Step count, with N_ITER = 16: 18 steps (4 and 13 repeated). Latency from the accept cycle T: ld_en at T+1, it_en at T+2..T+19, out_valid from T+20.
- DONE: out_valid = 1 and held until out_ready. On out_ready the next state is IDLE, so back-to-back operations have one idle cycle between them.
- abort: has priority in every state. The next state is IDLE, counters and flags are cleared, and no out_valid is produced. Abort together with in_valid in IDLE means the request is not accepted. Abort together with out_ready in DONE goes to IDLE; the consumer must ignore that result.
- in_valid outside IDLE is ignored and in_ready stays 0. y_neg is sampled only while it_en = 1.
- Async reset mid-operation returns immediately to reset values.

Optional Feature:
CORDIC_SQRT_REPEAT_EN
- Defined: repeat iterations at 4, 13, 40, ... as above. With N_ITER = 16 this gives 18 steps.
- Undefined: there is no repeat logic, rep_flag and next_rep are removed, and i steps 1..N_ITER once. This gives 16 steps and out_valid at T+18, at reduced accuracy.

Decomposition:
- Package cordic_sqrt_pkg holds:
  - the state enum (IDLE, LOAD, ITER, DONE);
  - FIRST_REPEAT = 4;
  - the repeat recurrence constants (multiplier 3, offset 1);
  - the default N_ITER and SHIFT_W.
- One sub-module, cordic_iter_seq, holds the index, rep_flag and next_rep registers. Its interface is clear, step, idx, last.
- The FSM and handshakes stay in cordic_sqrt_ctrl.

Test Plan:
1. Reset, then N_ITER = 16 with repeats: single request at cycle 10.
   - in_ready drops at 11 and ld_en is high at 11.
   - shift_amt = 1,2,3,4,4,5,...,13,13,14,15,16 on cycles 12..29.
   - out_valid rises at 30.
2. y_neg toggled randomly during ITER → dir equals y_neg on exactly the it_en cycles and is 0 elsewhere.
3. out_ready held low for 5 cycles in DONE → out_valid stays 1 and busy stays 1. The out_ready pulse returns to IDLE the next cycle, and a new in_valid is accepted there.
4. abort at the 7th ITER cycle → IDLE the next cycle, in_ready = 1, and no out_valid. A subsequent request restarts at i = 1.
5. rst_n asserted asynchronously mid-ITER (between edges) → outputs take reset values immediately. After release, a normal operation completes with full latency.
6. Build without CORDIC_SQRT_REPEAT_EN → shift_amt runs 1..16 with no repeats, and out_valid appears 18 cycles after accept.
